// File: rtl/tt_ctrl_sel_driver_pkg.sv
// Shared definitions for the mux address-select spine transmitter.
// The decoder side uses the same N_ADDR so address widths match.
package tt_ctrl_sel_driver_pkg;

    localparam int unsigned N_ADDR_DEF  = 10;
    localparam int unsigned PULSE_W_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_GAP    = 3'd2,
        ST_INC_HI = 3'd3,
        ST_INC_LO = 3'd4,
        ST_ENA    = 3'd5
    } sel_state_e;

endpackage

// File: rtl/tt_ctrl_sel_phase_timer.sv
// Phase timer: flags phase_done_o on the last cycle of a PULSE_W-long phase.
// It clears on restart_i and also on every phase_done_o, so back-to-back phases need no reload.
module tt_ctrl_sel_phase_timer
    import tt_ctrl_sel_driver_pkg::*;
#(
    parameter int unsigned PULSE_W = PULSE_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic phase_done_o
);

    localparam int unsigned CW = $clog2(PULSE_W + 1);
    localparam logic [CW-1:0] LAST = CW'(PULSE_W - 1);

    logic [CW-1:0] cnt_q;

    assign phase_done_o = (cnt_q == LAST);

    // Phase counter: starts from zero on each phase entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart_i || phase_done_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/tt_ctrl_sel_driver.sv
// Controller-side transmitter for the mux select spine: select-reset pulse,
// one increment pulse per address step, then enable. All outputs registered.
module tt_ctrl_sel_driver
    import tt_ctrl_sel_driver_pkg::*;
#(
    parameter int unsigned N_ADDR  = N_ADDR_DEF,
    parameter int unsigned PULSE_W = PULSE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_ADDR-1:0] addr,
    output logic              busy,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    sel_state_e        state_q;
    logic [N_ADDR-1:0] rem_q;
    logic              busy_q;
    logic              sel_rst_n_q;
    logic              inc_q;
    logic              ena_q;
    logic              accept_s;
    logic              phase_done_s;

    // A new request is taken only from IDLE or ENA; start while busy is dropped.
    assign accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_ENA));

    tt_ctrl_sel_phase_timer #(
        .PULSE_W (PULSE_W)
    ) u_phase_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart_i    (accept_s),
        .phase_done_o (phase_done_s)
    );

    // Select sequence FSM with its registered spine outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            sel_rst_n_q <= 1'b0;
            inc_q       <= 1'b0;
            ena_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ENA: begin
                    if (accept_s) begin
                        state_q     <= ST_RST;
                        rem_q       <= addr;
                        busy_q      <= 1'b1;
                        sel_rst_n_q <= 1'b0;
                        inc_q       <= 1'b0;
                        ena_q       <= 1'b0;
                    end
                end
                ST_RST: begin
                    if (phase_done_s) begin
                        state_q     <= ST_GAP;
                        sel_rst_n_q <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (phase_done_s) begin
                        if (rem_q == '0) begin
                            state_q <= ST_ENA;
                            ena_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_INC_HI;
                            inc_q   <= 1'b1;
                        end
                    end
                end
                ST_INC_HI: begin
                    if (phase_done_s) begin
                        state_q <= ST_INC_LO;
                        inc_q   <= 1'b0;
                    end
                end
                ST_INC_LO: begin
                    // rem_q is nonzero here, so the decrement cannot wrap.
                    if (phase_done_s) begin
                        rem_q <= rem_q - N_ADDR'(1);
                        if (rem_q == N_ADDR'(1)) begin
                            state_q <= ST_ENA;
                            ena_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_INC_HI;
                            inc_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rem_q       <= '0;
                    busy_q      <= 1'b0;
                    sel_rst_n_q <= 1'b0;
                    inc_q       <= 1'b0;
                    ena_q       <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign ctrl_sel_rst_n = sel_rst_n_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_ena       = ena_q;

endmodule

// File: tb/tb_tt_ctrl_sel_driver.sv
// Directed bench for tt_ctrl_sel_driver (N_ADDR=10, PULSE_W=2).
module tb_tt_ctrl_sel_driver;

    localparam int PW = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] addr;
    logic       busy;
    logic       ctrl_sel_rst_n;
    logic       ctrl_sel_inc;
    logic       ctrl_ena;

    int n_cmp = 0;
    int n_err = 0;

    tt_ctrl_sel_driver #(
        .N_ADDR  (10),
        .PULSE_W (PW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .addr           (addr),
        .busy           (busy),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue start with address a and follow the sequence until ctrl_ena rises.
    // If inject >= 0, a start with addr=5 is pulsed at that cycle offset.
    task automatic run_seq(input string tag, input logic [9:0] a, input int inject,
                           input int exp_lat, input int exp_inc, input int exp_first);
        int   k, incs, rst_lo, first_inc, overlap;
        logic prev_inc, prev_busy;
        start = 1'b1;
        addr  = a;
        tick();
        start = 1'b0;
        k = 0; incs = 0; rst_lo = 0; first_inc = -1; overlap = 0;
        prev_inc = 1'b0; prev_busy = 1'b0;
        check_val({tag, "/ena_drop"}, int'(ctrl_ena), 0);
        check_val({tag, "/busy_set"}, int'(busy), 1);
        while (!ctrl_ena && k < 6000) begin
            if (!ctrl_sel_rst_n) rst_lo++;
            if (ctrl_sel_inc && !prev_inc) begin
                incs++;
                if (first_inc < 0) first_inc = k;
            end
            if (ctrl_sel_inc && !ctrl_sel_rst_n) overlap++;
            prev_inc  = ctrl_sel_inc;
            prev_busy = busy;
            if (k == inject) begin
                start = 1'b1;
                addr  = 10'd5;
            end
            tick();
            start = 1'b0;
            k++;
        end
        check_val({tag, "/latency"}, k, exp_lat);
        check_val({tag, "/inc_edges"}, incs, exp_inc);
        check_val({tag, "/first_inc"}, first_inc, exp_first);
        check_val({tag, "/rst_low_cycles"}, rst_lo, PW);
        check_val({tag, "/inc_during_rst"}, overlap, 0);
        check_val({tag, "/busy_fall"}, int'(busy), 0);
        check_val({tag, "/busy_before_ena"}, int'(prev_busy), 1);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        start = 1'b0;
        addr  = 10'd0;
        repeat (3) tick();
        check_val("rst/sel_rst_n", int'(ctrl_sel_rst_n), 0);
        check_val("rst/inc", int'(ctrl_sel_inc), 0);
        check_val("rst/ena", int'(ctrl_ena), 0);
        check_val("rst/busy", int'(busy), 0);

        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ctrl_sel_rst_n || ctrl_sel_inc || ctrl_ena || busy) bad++;
        end
        check_val("idle/stable_50", bad, 0);

        run_seq("a3",    10'd3,    -1, 16,   3,    4);
        run_seq("a0",    10'd0,    -1, 4,    0,    -1);
        run_seq("a1023", 10'd1023, -1, 4096, 1023, 4);
        run_seq("a2_inj", 10'd2,   5,  12,   2,    4);
        run_seq("a5_ena", 10'd5,   -1, 24,   5,    4);

        // Hold ENA a while: enable must persist without a new start.
        repeat (10) tick();
        check_val("ena/hold", int'(ctrl_ena), 1);

        // Asynchronous reset in the middle of an increment-high phase.
        start = 1'b1;
        addr  = 10'd3;
        tick();
        start = 1'b0;
        bad = 0;
        while (!ctrl_sel_inc && bad < 20) begin
            tick();
            bad++;
        end
        check_val("async/reached_inc_hi", int'(ctrl_sel_inc), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async/inc", int'(ctrl_sel_inc), 0);
        check_val("async/ena", int'(ctrl_ena), 0);
        check_val("async/sel_rst_n", int'(ctrl_sel_rst_n), 0);
        check_val("async/busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_val("post_rst/sel_rst_n", int'(ctrl_sel_rst_n), 0);
        check_val("post_rst/busy", int'(busy), 0);

        run_seq("a1_after_rst", 10'd1, -1, 8, 1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
